// File: rtl/mvu_csr_apb_if.sv
// CSR write request handshake plus APB write bus between the
// controller CSR path and the MVU configuration slave.
interface mvu_csr_apb_if #(
  parameter int BMVUA  = 3,
  parameter int ADDR_W = BMVUA + 12,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [BMVUA-1:0]  req_mvu_id;
  logic [11:0]       req_csr;
  logic [DATA_W-1:0] req_wdata;
  logic [ADDR_W-1:0] paddr;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [DATA_W-1:0] pwdata;
  logic              pready;
  logic              pslverr;

  modport master (
    input  req_valid, req_mvu_id, req_csr, req_wdata,
    input  pready, pslverr,
    output req_ready,
    output paddr, psel, penable, pwrite, pwdata
  );

  modport slave (
    output req_valid, req_mvu_id, req_csr, req_wdata,
    output pready, pslverr,
    input  req_ready,
    input  paddr, psel, penable, pwrite, pwdata
  );
endinterface

// File: rtl/mvu_csr_apb_master.sv
// Buffers MVU CSR write requests in a FIFO and issues each
// one as an APB write, with wait-state and timeout handling.
module mvu_csr_apb_master #(
  parameter int BMVUA      = 3,
  parameter int ADDR_W     = BMVUA + 12,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  mvu_csr_apb_if.master bus,
  output logic          busy,
  output logic          err_pulse,
  output logic          err_timeout,
  output logic [15:0]   wr_count
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int TO_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef struct packed {
    logic [BMVUA-1:0]  mvu_id;
    logic [11:0]       csr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  req_t             mem [FIFO_DEPTH];
  req_t             req_in;
  req_t             head;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [TO_W-1:0]  to_cnt;
  state_t           state;
  state_t           state_nxt;
  logic             push;
  logic             pop;
  logic             cpl;
  logic             abort;
  logic             load;
  logic             empty;
  logic             last;
  logic             to_hit;
  logic             psel;
  logic             penable;

  assign req_in = '{
    mvu_id: bus.req_mvu_id,
    csr:    bus.req_csr,
    wdata:  bus.req_wdata
  };

  assign empty         = (count == '0);
  assign last          = (count == CNT_W'(1));
  assign bus.req_ready = (count != CNT_W'(FIFO_DEPTH));
  assign push          = bus.req_valid && bus.req_ready;
  assign pop           = cpl || abort;
  assign busy          = !empty || (state != IDLE);

  assign to_hit = (TIMEOUT != 0) &&
                  (to_cnt == TO_W'(TIMEOUT - 1));

  // On a back-to-back pop the next head may be the entry
  // being pushed this very cycle, so bypass it.
  always_comb begin
    head = mem[rd_ptr];
    if (pop) begin
      if (last) head = req_in;
      else      head = mem[rd_ptr + 1'b1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:   if (!empty) state_nxt = SETUP;
      SETUP:  state_nxt = ACCESS;
      ACCESS: begin
        if (abort)
          state_nxt = IDLE;
        else if (cpl)
          state_nxt = (!last || push) ? SETUP : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    psel    = 1'b0;
    penable = 1'b0;
    cpl     = 1'b0;
    abort   = 1'b0;
    unique case (state)
      IDLE:  ;
      SETUP: psel = 1'b1;
      ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
        cpl     = bus.pready;
        abort   = !bus.pready && to_hit;
      end
      default: ;
    endcase
  end

  assign load        = (state_nxt == SETUP);
  assign bus.psel    = psel;
  assign bus.penable = penable;
  assign bus.pwrite  = psel;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= req_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
    end else if (state == SETUP) begin
      to_cnt <= '0;
    end else if (state == ACCESS && !bus.pready && !to_hit) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.paddr  <= '0;
      bus.pwdata <= '0;
    end else if (load) begin
      bus.paddr  <= {head.mvu_id, head.csr};
      bus.pwdata <= head.wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_pulse   <= 1'b0;
      err_timeout <= 1'b0;
      wr_count    <= '0;
    end else begin
      err_pulse   <= (cpl && bus.pslverr) || abort;
      err_timeout <= err_timeout || abort;
      if (cpl) wr_count <= wr_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_mvu_csr_apb_master.sv
// Directed self-checking bench for mvu_csr_apb_master with a
// small APB slave/monitor driven from the bench.
module tb_mvu_csr_apb_master;

  logic        clk;
  logic        rst_n;
  logic        busy;
  logic        err_pulse;
  logic        err_timeout;
  logic [15:0] wr_count;

  mvu_csr_apb_if bus ();

  mvu_csr_apb_master dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .busy       (busy),
    .err_pulse  (err_pulse),
    .err_timeout(err_timeout),
    .wr_count   (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [14:0] cpl_addr [$];
  logic [31:0] cpl_data [$];
  logic [14:0] last_cpl;
  logic [14:0] err_after;
  logic [14:0] err_addr;
  logic        err_en;
  int          err_cnt;
  int          psel_cyc;
  int          gaps;
  bit          seen_psel;
  bit          saw_full;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h",
               tag, got, exp);
    end
  endtask

  always @(*) bus.pslverr = err_en && bus.psel &&
                            (bus.paddr == err_addr);

  always @(posedge clk) begin
    if (rst_n) begin
      if (bus.psel) begin
        psel_cyc++;
        seen_psel = 1'b1;
      end else if (seen_psel && busy) begin
        gaps++;
      end
      if (bus.psel && bus.penable && bus.pready) begin
        cpl_addr.push_back(bus.paddr);
        cpl_data.push_back(bus.pwdata);
        last_cpl = bus.paddr;
      end
      if (err_pulse) begin
        err_cnt++;
        err_after = last_cpl;
      end
    end
  end

  task automatic do_reset(input logic rdy);
    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.pready    = rdy;
    err_en        = 1'b0;
    repeat (2) @(posedge clk);
    cpl_addr.delete();
    cpl_data.delete();
    err_cnt   = 0;
    psel_cyc  = 0;
    gaps      = 0;
    seen_psel = 1'b0;
    saw_full  = 1'b0;
    last_cpl  = '0;
    err_after = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0]  id,
                      input logic [11:0] csr,
                      input logic [31:0] data);
    bit hs;
    bus.req_valid  = 1'b1;
    bus.req_mvu_id = id;
    bus.req_csr    = csr;
    bus.req_wdata  = data;
    for (int k = 0; k < 200; k++) begin
      hs = bus.req_ready;
      if (!hs) saw_full = 1'b1;
      @(posedge clk);
      #1;
      if (hs) break;
      if (k == 199) chk("push_timeout", 32'd0, 32'd1);
    end
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_wr(input int n);
    for (int k = 0; k < 500; k++) begin
      if (wr_count == 16'(n) && !busy) break;
      @(posedge clk);
      #1;
      if (k == 499) chk("wait_timeout", 32'(wr_count), 32'(n));
    end
  endtask

  logic [14:0] exp_a;
  logic [31:0] exp_d;
  int          acc;

  initial begin
    bus.req_mvu_id = '0;
    bus.req_csr    = '0;
    bus.req_wdata  = '0;
    do_reset(1'b1);

    chk("rst_psel",    32'(bus.psel),      32'd0);
    chk("rst_penable", 32'(bus.penable),   32'd0);
    chk("rst_pwrite",  32'(bus.pwrite),    32'd0);
    chk("rst_paddr",   32'(bus.paddr),     32'd0);
    chk("rst_pwdata",  bus.pwdata,         32'd0);
    chk("rst_ready",   32'(bus.req_ready), 32'd1);
    chk("rst_busy",    32'(busy),          32'd0);
    chk("rst_errp",    32'(err_pulse),     32'd0);
    chk("rst_errto",   32'(err_timeout),   32'd0);
    chk("rst_wrcnt",   32'(wr_count),      32'd0);

    // single write, exact latency
    push(3'd2, 12'h020, 32'hDEADBEEF);
    chk("t1_e0_psel", 32'(bus.psel), 32'd0);
    @(posedge clk); #1;
    chk("t1_e1_psel",  32'(bus.psel),    32'd1);
    chk("t1_e1_pen",   32'(bus.penable), 32'd0);
    chk("t1_paddr",    32'(bus.paddr),   32'h2020);
    chk("t1_pwdata",   bus.pwdata,       32'hDEADBEEF);
    @(posedge clk); #1;
    chk("t1_e2_pen",   32'(bus.penable), 32'd1);
    chk("t1_e2_pwr",   32'(bus.pwrite),  32'd1);
    @(posedge clk); #1;
    chk("t1_e3_psel",  32'(bus.psel),    32'd0);
    chk("t1_wrcnt",    32'(wr_count),    32'd1);
    chk("t1_busy",     32'(busy),        32'd0);

    // burst of six
    do_reset(1'b1);
    for (int i = 0; i < 6; i++)
      push(3'(i), 12'h100 + 12'(i), 32'hA5A50000 + 32'(i));
    wait_wr(6);
    chk("t2_full",  32'(saw_full),        32'd1);
    chk("t2_gaps",  32'(gaps),            32'd0);
    chk("t2_wrcnt", 32'(wr_count),        32'd6);
    chk("t2_n",     32'(cpl_addr.size()), 32'd6);
    for (int i = 0; i < 6 && i < cpl_addr.size(); i++) begin
      exp_a = {3'(i), 12'h100 + 12'(i)};
      exp_d = 32'hA5A50000 + 32'(i);
      chk($sformatf("t2_addr%0d", i), 32'(cpl_addr[i]), 32'(exp_a));
      chk($sformatf("t2_data%0d", i), cpl_data[i], exp_d);
    end
    chk("t2_psel_cyc", 32'(psel_cyc), 32'd12);

    // three wait states
    do_reset(1'b0);
    push(3'd5, 12'h044, 32'h12345678);
    acc = 0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #1;
      if (bus.psel && bus.penable) begin
        acc++;
        chk("t3_paddr",  32'(bus.paddr), 32'h5044);
        chk("t3_pwdata", bus.pwdata,     32'h12345678);
        if (acc == 4) bus.pready = 1'b1;
      end else if (acc > 0) begin
        break;
      end
    end
    chk("t3_acc",   32'(acc),         32'd4);
    chk("t3_wrcnt", 32'(wr_count),    32'd1);
    chk("t3_errs",  32'(err_cnt),     32'd0);
    chk("t3_errto", 32'(err_timeout), 32'd0);

    // slave error on the second of three
    do_reset(1'b1);
    err_en   = 1'b1;
    err_addr = 15'h1204;
    push(3'd1, 12'h200, 32'h11111111);
    push(3'd1, 12'h204, 32'h22222222);
    push(3'd1, 12'h208, 32'h33333333);
    wait_wr(3);
    @(posedge clk); #1;
    chk("t4_wrcnt",  32'(wr_count),    32'd3);
    chk("t4_errcnt", 32'(err_cnt),     32'd1);
    chk("t4_errat",  32'(err_after),   32'h1204);
    chk("t4_errto",  32'(err_timeout), 32'd0);
    chk("t4_errp",   32'(err_pulse),   32'd0);

    // timeout on a stuck slave
    do_reset(1'b0);
    push(3'd1, 12'h010, 32'hCAFE0001);
    push(3'd1, 12'h014, 32'hCAFE0002);
    acc = 0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      if (bus.psel && bus.penable) acc++;
      else if (acc > 0) break;
    end
    chk("t5_acc",    32'(acc),         32'd16);
    chk("t5_errp",   32'(err_pulse),   32'd1);
    chk("t5_errto",  32'(err_timeout), 32'd1);
    chk("t5_wrcnt0", 32'(wr_count),    32'd0);
    chk("t5_busy",   32'(busy),        32'd1);
    bus.pready = 1'b1;
    wait_wr(1);
    chk("t5_wrcnt1", 32'(wr_count),        32'd1);
    chk("t5_n",      32'(cpl_addr.size()), 32'd1);
    if (cpl_addr.size() > 0)
      chk("t5_addr", 32'(cpl_addr[0]), 32'h1014);
    chk("t5_errcnt", 32'(err_cnt),     32'd1);
    chk("t5_sticky", 32'(err_timeout), 32'd1);

    // reset in the middle of ACCESS
    do_reset(1'b0);
    push(3'd3, 12'h300, 32'h0);
    push(3'd3, 12'h304, 32'h1);
    push(3'd3, 12'h308, 32'h2);
    chk("t6_access", 32'(bus.psel && bus.penable), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_psel", 32'(bus.psel),    32'd0);
    chk("t6_pen",  32'(bus.penable), 32'd0);
    @(negedge clk);
    rst_n      = 1'b1;
    bus.pready = 1'b1;
    psel_cyc   = 0;
    repeat (10) @(posedge clk);
    #1;
    chk("t6_ready", 32'(bus.req_ready),   32'd1);
    chk("t6_busy",  32'(busy),            32'd0);
    chk("t6_apb",   32'(psel_cyc),        32'd0);
    chk("t6_wrcnt", 32'(wr_count),        32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
